// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per cycle, carry held in a register.
// Returns sum with carry, signed overflow and zero flags via a start/done handshake.
module seq_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nx;
  logic             carry, a_msb, b_msb;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic [CHUNK:0]   csum;
  logic [CHUNK+WIDTH-1:0] cat;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign busy   = (state == CALC);
  assign done   = (state == DONE);

  // Operands shift right each cycle; result chunks enter the accumulator from the top.
  always_comb begin
    csum   = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    cat    = {csum[CHUNK-1:0], acc};
    acc_nx = cat[CHUNK+WIDTH-1:CHUNK];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = start ? CALC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + ~cin, so borrow-in inverts like the operand.
      a_sh  <= a;
      b_sh  <= op_sub ? ~b : b;
      carry <= op_sub ? ~cin : cin;
      a_msb <= a[WIDTH-1];
      b_msb <= op_sub ? ~b[WIDTH-1] : b[WIDTH-1];
      acc   <= '0;
      cnt   <= '0;
    end else if (state == CALC) begin
      a_sh  <= a_sh >> CHUNK;
      b_sh  <= b_sh >> CHUNK;
      acc   <= acc_nx;
      carry <= csum[CHUNK];
      cnt   <= cnt + 1'b1;
      if (cnt == LAST) begin
        sum  <= acc_nx;
        cout <= csum[CHUNK];
        ovf  <= (a_msb == b_msb) && (acc_nx[WIDTH-1] != a_msb);
        zero <= ~|acc_nx;
      end
    end
  end

endmodule
